bus_interface_unit_ws: RTL and testbench

- Sequential successor to the combinational bus interface unit; sits between the control unit and the IO/data-memory buses.
- Accepts one load/store request at a time and decodes it to the IO or MEM region, using the same region map as today.
- Drives chip-select, write and read strobes for a parametrised number of wait states per region, captures read data, and returns a done/err handshake.
- Inactive strobes are driven to 0, never x.

---
 rtl/bus_interface_unit_ws.sv | 151 +++++++++++++++
 tb/tb_bus_interface_unit_ws.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bus_interface_unit_ws.sv
// Sequential bus interface unit: one load/store at a time to the IO or MEM region with per-region wait states.
// Optional BIU_BUS_READY_EN adds a bus_ready input that stretches ACCESS after the wait count expires.
module bus_interface_unit_ws #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] IO_START_ADDR  = 'h0000,
  parameter logic [ADDR_WIDTH-1:0] IO_STOP_ADDR   = 'h003F,
  parameter logic [ADDR_WIDTH-1:0] MEM_START_ADDR = 'h0040,
  parameter logic [ADDR_WIDTH-1:0] MEM_STOP_ADDR  = 'h00BF,
  parameter int unsigned IO_WAIT  = 0,
  parameter int unsigned MEM_WAIT = 1,
  parameter int WAIT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef BIU_BUS_READY_EN
  input  logic                  bus_ready,
`endif
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  io_cs,
  output logic                  io_we,
  output logic                  io_oe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t                state;
  logic [WAIT_WIDTH-1:0] cnt;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drive;

`ifndef BIU_BUS_READY_EN
  logic bus_ready;
  assign bus_ready = 1'b1;
`endif

  // Range check kept in a function so a START of zero does not read as a constant compare.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [ADDR_WIDTH-1:0] lo,
                                    input logic [ADDR_WIDTH-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  logic io_hit;
  logic mem_hit;
  assign io_hit  = in_range(req_addr, IO_START_ADDR, IO_STOP_ADDR);
  assign mem_hit = in_range(req_addr, MEM_START_ADDR, MEM_STOP_ADDR);

  // The drive enable is a register, so the bus is released by reset without waiting for a clock.
  assign bus_data = drive ? wdata_q : 'z;

  // NOTE: all state here is sequential and uses non-blocking assignments; every register,
  // data latches included, is async-reset so an aborted access leaves no stale strobe or drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      drive    <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bus_addr <= '0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_oe   <= 1'b0;
      io_cs    <= 1'b0;
      io_we    <= 1'b0;
      io_oe    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= req_we;
            wdata_q <= req_wdata;
            busy    <= 1'b1;
            if (io_hit) begin
              state    <= ACCESS;
              cnt      <= WAIT_WIDTH'(IO_WAIT);
              io_cs    <= 1'b1;
              io_we    <= req_we;
              io_oe    <= !req_we;
              bus_addr <= req_addr - IO_START_ADDR;
              drive    <= req_we;
            end else if (mem_hit) begin
              state    <= ACCESS;
              cnt      <= WAIT_WIDTH'(MEM_WAIT);
              mem_cs   <= 1'b1;
              mem_we   <= req_we;
              mem_oe   <= !req_we;
              bus_addr <= req_addr - MEM_START_ADDR;
              drive    <= req_we;
            end else begin
              state <= ERROR;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end

        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (bus_ready) begin
            if (!we_q) rdata <= bus_data;
            state    <= DONE;
            done     <= 1'b1;
            drive    <= 1'b0;
            bus_addr <= '0;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_oe   <= 1'b0;
            io_cs    <= 1'b0;
            io_we    <= 1'b0;
            io_oe    <= 1'b0;
          end
        end

        DONE, ERROR: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interface_unit_ws.sv
// Directed bench for bus_interface_unit_ws with small IO/MEM read models on the shared data bus.
module tb_bus_interface_unit_ws;

  logic        clk;
  logic        reset;
  logic        req;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  rdata;
  logic        busy, done, err;
  logic [15:0] bus_addr;
  wire  [7:0]  bus_data;
  logic        mem_cs, mem_we, mem_oe;
  logic        io_cs, io_we, io_oe;
  logic        bus_ready;
  logic [7:0]  mem_val;
  logic [7:0]  io_val;

  int n_checks = 0;
  int n_errors = 0;

  bus_interface_unit_ws dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef BIU_BUS_READY_EN
    .bus_ready (bus_ready),
`endif
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .io_cs     (io_cs),
    .io_we     (io_we),
    .io_oe     (io_oe)
  );

  assign bus_data = (mem_cs && mem_oe) ? mem_val :
                    (io_cs && io_oe)   ? io_val  : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // region: 0 = IO, 1 = MEM, 2 = unmapped
  task automatic do_access(input string tag, input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata, input int region,
                           input logic [15:0] offset, input int waits,
                           input logic [7:0] exp_rdata);
    req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    tick();
    if (region == 2) begin
      check({tag, ".done"}, done, 1);
      check({tag, ".err"}, err, 1);
      check({tag, ".io_cs"}, io_cs, 0);
      check({tag, ".mem_cs"}, mem_cs, 0);
      check({tag, ".rdata"}, rdata, exp_rdata);
    end else begin
      for (int c = 1; c <= waits + 1; c++) begin
        check({tag, ".io_cs"}, io_cs, region == 0);
        check({tag, ".mem_cs"}, mem_cs, region == 1);
        check({tag, ".we"}, (region == 0) ? io_we : mem_we, we);
        check({tag, ".oe"}, (region == 0) ? io_oe : mem_oe, !we);
        check({tag, ".bus_addr"}, bus_addr, offset);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".done_early"}, done, 0);
        if (we) check({tag, ".bus_data"}, bus_data, wdata);
        tick();
      end
      check({tag, ".done"}, done, 1);
      check({tag, ".err"}, err, 0);
      check({tag, ".cs_off"}, {io_cs, mem_cs}, 0);
      check({tag, ".rdata"}, rdata, exp_rdata);
    end
    req = 1'b0;
    tick();
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".idle_done"}, done, 0);
  endtask

  initial begin
    int n_done;
    int io_seen;
    reset = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b1; mem_val = 8'h00; io_val = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst.rdata", rdata, 0);
    check("rst.flags", {busy, done, err}, 0);
    check("rst.strobes", {mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe}, 0);
    check("rst.bus_addr", bus_addr, 0);
    reset = 1'b1;
    tick();

    mem_val = 8'hA5;
    do_access("mem_load", 1'b0, 16'h0045, 8'h00, 1, 16'h0005, 1, 8'hA5);
    do_access("io_store", 1'b1, 16'h003F, 8'h5C, 0, 16'h003F, 0, 8'hA5);
    do_access("unmapped", 1'b0, 16'h00C0, 8'h00, 2, 16'h0000, 0, 8'hA5);
    mem_val = 8'h3C;
    do_access("mem_lo", 1'b0, 16'h0040, 8'h00, 1, 16'h0000, 1, 8'h3C);
    mem_val = 8'h7E;
    do_access("mem_hi", 1'b0, 16'h00BF, 8'h00, 1, 16'h007F, 1, 8'h7E);
    io_val = 8'h11;
    do_access("io_lo", 1'b0, 16'h0000, 8'h00, 0, 16'h0000, 0, 8'h11);

    // Second request pulsed while busy must be dropped.
    mem_val = 8'h9D; n_done = 0; io_seen = 0;
    req = 1'b1; req_we = 1'b0; req_addr = 16'h0050;
    tick();
    req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) begin req = 1'b1; req_we = 1'b1; req_addr = 16'h0010; end
      if (c == 3) req = 1'b0;
      if (done) n_done++;
      if (io_cs) io_seen++;
      tick();
    end
    check("ignored.done_count", n_done, 1);
    check("ignored.io_cs", io_seen, 0);
    check("ignored.rdata", rdata, 8'h9D);

    // Asynchronous abort in the middle of a MEM store.
    req = 1'b1; req_we = 1'b1; req_addr = 16'h0060; req_wdata = 8'h77;
    tick();
    check("abort.pre_cs", {mem_cs, mem_we}, 2'b11);
    check("abort.pre_data", bus_data, 8'h77);
    req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort.strobes", {mem_cs, mem_we, mem_oe}, 0);
    check("abort.busy", busy, 0);
    check("abort.rdata", rdata, 0);
    check("abort.released", bus_data === 8'h77, 0);
    #4 reset = 1'b1;
    tick();

    io_val = 8'h4B;
    do_access("io_post", 1'b0, 16'h0020, 8'h00, 0, 16'h0020, 0, 8'h4B);

`ifdef BIU_BUS_READY_EN
    // MEM_WAIT=1 plus three not-ready cycles: ACCESS spans cycles 1..5, done in cycle 6.
    mem_val = 8'h12; bus_ready = 1'b0;
    req = 1'b1; req_we = 1'b0; req_addr = 16'h0045;
    tick();
    for (int c = 1; c <= 5; c++) begin
      check("ready.mem_cs", mem_cs, 1);
      check("ready.done_early", done, 0);
      if (c == 5) begin bus_ready = 1'b1; mem_val = 8'hC3; end
      tick();
    end
    check("ready.done", done, 1);
    check("ready.rdata", rdata, 8'hC3);
    req = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
